// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM access arbiter.
package rom_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 32;

  // Data returned to a requester whose access timed out.
  localparam logic [ROM_DATA_W-1:0] ROM_ERR_DATA = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN,
    BIST
  } rom_arb_state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: request/address in, grant/response out.
interface rom_arbiter_if import rom_pkg::*; #(
  parameter int NUM_PORTS = 3
) ();

  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0][ROM_ADDR_W-1:0] addr_i;
  logic [NUM_PORTS-1:0]                 gnt_o;
  logic [NUM_PORTS-1:0]                 rvalid_o;
  logic [ROM_DATA_W-1:0]                rdata_o;
  logic                                 rerr_o;

  // Arbiter side.
  modport slave (
    input  req_i,
    input  addr_i,
    output gnt_o,
    output rvalid_o,
    output rdata_o,
    output rerr_o
  );

  // Requester side.
  modport master (
    output req_i,
    output addr_i,
    input  gnt_o,
    input  rvalid_o,
    input  rdata_o,
    input  rerr_o
  );

endinterface

// File: rtl/rom_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_picker #(
  parameter int NUM_PORTS = 3,
  parameter int LW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [LW-1:0]        last_grant,
  output logic                 vld,
  output logic [LW-1:0]        win
);

  int idx;

  // Scan ports last_grant+1 .. last_grant+NUM_PORTS (mod NUM_PORTS), keep the first hit.
  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        win = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one ROM controller between NUM_PORTS requesters,
// with access timeout and an MBIST mode that drains any outstanding access first.
module rom_arbiter import rom_pkg::*; #(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_arbiter_if.slave          bus,
  output logic                  rom_req,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_rdata,
  input  logic                  rom_ready,
  input  logic                  bist_req_i,
  output logic                  mbist_en,
  input  logic                  mbist_done,
  output logic                  bist_done_o
);

  localparam int LW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TIMEOUT + 1);

  rom_arb_state_t        state_q, state_d;
  // last_grant doubles as the owner of the outstanding access: it only moves on issue.
  logic [LW-1:0]         last_q;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic                  pick_vld;
  logic [LW-1:0]         pick_win;
  logic                  timed_out;
  logic [NUM_PORTS-1:0]  gnt, rvalid;
  logic [ROM_DATA_W-1:0] rdata;
  logic                  rerr;
  logic                  bist_done;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req        (bus.req_i),
    .last_grant (last_q),
    .vld        (pick_vld),
    .win        (pick_win)
  );

  assign timed_out = !rom_ready && (tcnt_q == TW'(TIMEOUT - 1));

  // Next-state and output decode; everything is forced quiet while rst is high.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    gnt       = '0;
    rvalid    = '0;
    rdata     = '0;
    rerr      = 1'b0;
    rom_req   = 1'b0;
    rom_addr  = '0;
    mbist_en  = 1'b0;
    bist_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (bist_req_i) begin
          mbist_en = 1'b1;
          state_d  = BIST;
        end else if (pick_vld) begin
          issue = 1'b1;
        end
      end
      WAIT, DRAIN: begin
        if (rom_ready || timed_out) begin
          rvalid[last_q] = 1'b1;
          rerr           = !rom_ready;
          rdata          = rom_ready ? rom_rdata : ROM_ERR_DATA;
          if (state_q == DRAIN || bist_req_i) begin
            state_d = BIST;
          end else if (rom_ready && pick_vld) begin
            issue = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (bist_req_i) begin
            state_d = DRAIN;
          end
        end
      end
      BIST: begin
        if (bist_req_i) begin
          mbist_en  = 1'b1;
          done_d    = done_q | mbist_done;
          bist_done = done_d;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      gnt[pick_win] = 1'b1;
      rom_req       = 1'b1;
      rom_addr      = bus.addr_i[pick_win];
      state_d       = WAIT;
      tcnt_d        = '0;
    end

    if (rst) begin
      gnt       = '0;
      rvalid    = '0;
      rdata     = '0;
      rerr      = 1'b0;
      rom_req   = 1'b0;
      rom_addr  = '0;
      mbist_en  = 1'b0;
      bist_done = 1'b0;
    end
  end

  // Control registers: FSM state, round-robin pointer, timeout counter, MBIST done latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LW'(NUM_PORTS - 1);
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      if (issue) begin
        last_q <= pick_win;
      end
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;
  assign bus.rerr_o   = rerr;
  assign bist_done_o  = bist_done;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Param NUM_PORTS, default 3, number of requesters (2..4).
REQ-002 Param TIMEOUT, default 4, max cycles from issue to rom_ready before error.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_i  in  NUM_PORTS  per-port access request, held until granted.
REQ-007 addr_i  in  NUM_PORTS x 15  per-port byte address, stable while req_i high.
REQ-008 gnt_o  out  NUM_PORTS  one-hot grant, same cycle as rom_req.
REQ-009 rvalid_o  out  NUM_PORTS  one-hot response valid to the granted port.
REQ-010 rdata_o  out  32  shared response data, valid when any rvalid_o high.
REQ-011 rerr_o  out  1  response is a timeout error, qualified by rvalid_o.
REQ-012 rom_req  out  1  to ROM controller access request.
REQ-013 rom_addr  out  15  to ROM controller address.
REQ-014 rom_rdata  in  32  from ROM controller read data.
REQ-015 rom_ready  in  1  from ROM controller, data valid 1 cycle after rom_req.
REQ-016 bist_req_i  in  1  level request to run ROM MBIST.
REQ-017 mbist_en  out  1  to ROM controller MBIST enable.
REQ-018 mbist_done  in  1  from ROM controller.
REQ-019 bist_done_o  out  1  MBIST complete, level, cleared when bist_req_i drops.

Function
REQ-020 FSM states: IDLE, WAIT, DRAIN, BIST; reset state IDLE.
REQ-021 Issue permitted in IDLE, or in WAIT in the cycle rom_ready arrives; throughput one access per cycle.
REQ-022 On issue: rom_req=1, rom_addr=addr_i[winner], gnt_o[winner]=1, owner and state WAIT registered.
REQ-023 Winner: round-robin, search starts at last_grant+1 mod NUM_PORTS; last_grant updates only on issue.
REQ-024 WAIT with rom_ready: rvalid_o[owner]=1, rdata_o=rom_rdata, rerr_o=0; next state WAIT if new issue else IDLE.
REQ-025 WAIT: timeout counter counts cycles without rom_ready; at TIMEOUT it SHALL pulse rvalid_o[owner], rerr_o=1, rdata_o=32'h0, go IDLE.
REQ-026 Late rom_ready arriving in IDLE or BIST SHALL be discarded, no rvalid_o.
REQ-027 bist_req_i high in IDLE: mbist_en=1, state BIST next cycle; no issue that cycle.
REQ-028 bist_req_i high in WAIT: no new issue, state DRAIN; DRAIN completes the outstanding response or timeout, then BIST.
REQ-029 bist_req_i takes precedence over req_i in the same cycle.
REQ-030 BIST: mbist_en=1, gnt_o=0, rom_req=0; bist_done_o follows mbist_done latched high.
REQ-031 BIST with bist_req_i low: mbist_en=0, bist_done_o=0, state IDLE next cycle.
REQ-032 gnt_o, rvalid_o SHALL be one-hot or zero every cycle; outputs not named as driven SHALL be 0.

Reset
REQ-033 On rst: state IDLE, last_grant=NUM_PORTS-1, timeout counter 0, all outputs 0, rdata_o=32'h0.
REQ-034 Reset mid-WAIT or mid-BIST SHALL abandon the access or test without rvalid_o; mbist_en=0 the following cycle.

Structure
REQ-035 Shared package rom_pkg: FSM enum rom_arb_state_t, ROM_ADDR_W=15, ROM_DATA_W=32, timeout error data constant.
REQ-036 One sub-module rr_picker: combinational round-robin winner from req vector and last_grant.

Verification
REQ-037 Reset, then req_i=3'b001, addr 0x0040 -> cycle 0: gnt_o=001, rom_addr=0x0040; cycle 1: rvalid_o=001, rdata_o=rom_rdata.
REQ-038 req_i=3'b111 held 6 cycles, ROM answering -> grants 001,010,100,001,010,100, one per cycle, rvalid_o trails by 1.
REQ-039 rom_ready held low after issue -> rvalid_o[owner]=1 with rerr_o=1, rdata_o=0 at cycle 4 after issue; state IDLE.
REQ-040 bist_req_i raised in WAIT with req_i=3'b011 -> outstanding response delivered, no further gnt_o, mbist_en=1 next cycle; mbist_done=1 -> bist_done_o=1; drop bist_req_i -> bist_done_o=0 and port 1 granted.
REQ-041 rst asserted in WAIT, rom_ready next cycle -> no rvalid_o, all outputs 0, first post-reset grant to port 0.
